// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encodings and default sizing.
package fifo_wr_arbiter_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam int DEF_BURST_MAX   = 4;
   localparam int DEF_TIMEOUT_CYC = 16;

   // Index width for a requester number; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after prio_ptr, with wrap.
module rr_pick
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IW    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    prio_ptr,
   output logic [N_REQ-1:0] pick,
   output logic [IW-1:0]    pick_idx
);

   logic [IW-1:0] cand;

   // Walk from lowest to highest priority so the last hit is the winner.
   always_comb begin
      pick     = '0;
      pick_idx = '0;
      cand     = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = IW'((int'(prio_ptr) + k) % N_REQ);
         if (req[cand]) begin
            pick       = '0;
            pick[cand] = 1'b1;
            pick_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among N_REQ producers.
// Optional stall timeout enabled by defining ARB_TIMEOUT_EN.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int dat_width   = 8,
   parameter int BURST_MAX   = DEF_BURST_MAX,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ*dat_width-1:0]   req_data,
   input  logic [N_REQ-1:0]             req_last,
   output logic [N_REQ-1:0]             gnt,
   output logic [N_REQ-1:0]             ack,
   input  logic                         fifo_full,
   output logic                         fifo_wr,
   output logic [dat_width-1:0]         fifo_data,
   output logic                         busy,
   output logic                         timeout
);

   localparam int IW = idx_width(N_REQ);

   logic [0:0]       state_q, state_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [7:0]       burst_cnt_q, burst_cnt_d;
   logic [IW-1:0]    prio_ptr_q, prio_ptr_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;

   logic [N_REQ-1:0]     pick;
   logic [IW-1:0]        pick_idx;
   logic                 in_grant;
   logic                 req_owner;
   logic                 last_owner;
   logic                 accept;
   logic                 release_c;
   logic                 timeout_hit;
   logic [dat_width-1:0] sel_data;

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr_pick (
      .req      (req),
      .prio_ptr (prio_ptr_q),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == IW'(i)) begin
            sel_data = req_data[i*dat_width +: dat_width];
         end
      end
   end

   assign in_grant   = (state_q == ST_GRANT);
   assign req_owner  = req[owner_q];
   assign last_owner = req_last[owner_q];
   // A word is only taken while the owner still presents it and the FIFO has room.
   assign accept     = in_grant & req_owner & ~fifo_full;
   assign release_c  = in_grant &
                       ((accept & (last_owner | (burst_cnt_q == 8'(BURST_MAX - 1)))) |
                        ~req_owner | timeout_hit);

`ifdef ARB_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

   logic [STALL_W-1:0] stall_q, stall_d;

   // Counts consecutive GRANT cycles without a write; IDLE clears it for the next grant.
   always_comb begin
      stall_d     = stall_q;
      timeout_hit = 1'b0;
      if (!in_grant || accept) begin
         stall_d = '0;
      end else begin
         stall_d = stall_q + 1'b1;
         if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
            timeout_hit = req_owner;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      prio_ptr_d  = prio_ptr_q;
      gnt_d       = gnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               owner_d     = pick_idx;
               gnt_d       = pick;
               burst_cnt_d = '0;
               state_d     = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (accept) begin
               burst_cnt_d = burst_cnt_q + 8'd1;
            end
            // The releasing owner becomes lowest priority at the next arbitration.
            if (release_c) begin
               state_d    = ST_IDLE;
               gnt_d      = '0;
               prio_ptr_d = owner_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         burst_cnt_q <= '0;
         prio_ptr_q  <= IW'(N_REQ - 1);
         gnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         prio_ptr_q  <= prio_ptr_d;
         gnt_q       <= gnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign ack       = accept ? gnt_q : '0;
   assign fifo_wr   = accept;
   assign fifo_data = accept ? sel_data : '0;
   assign busy      = in_grant;
   assign timeout   = timeout_hit;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: arbitration order, bursts, backpressure, reset, timeout.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic        fifo_full;
   logic        fifo_wr;
   logic [7:0]  fifo_data;
   logic        busy;
   logic        timeout;

   int total;
   int bad;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   fifo_wr_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_data  (req_data),
      .req_last  (req_last),
      .gnt       (gnt),
      .ack       (ack),
      .fifo_full (fifo_full),
      .fifo_wr   (fifo_wr),
      .fifo_data (fifo_data),
      .busy      (busy),
      .timeout   (timeout)
   );

   // clock / reset block: inputs change on the falling edge, DUT flops on the rising edge
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model: every strobe observed mid-cycle is one word stored
   always @(negedge clk) begin
      #2;
      if (fifo_wr === 1'b1) got_q.push_back(fifo_data);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic set_word(input int i, input logic [7:0] v);
      req_data[i*8 +: 8] = v;
   endtask

   task automatic chk_write(input string tag, input logic [3:0] who, input logic [7:0] v);
      chk({tag, "_gnt"}, 32'(gnt), 32'(who));
      chk({tag, "_ack"}, 32'(ack), 32'(who));
      chk({tag, "_wr"}, 32'(fifo_wr), 32'd1);
      chk({tag, "_data"}, 32'(fifo_data), 32'(v));
      exp_q.push_back(v);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_wr"}, 32'(fifo_wr), 32'd0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      req       = '0;
      req_data  = '0;
      req_last  = '0;
      fifo_full = 1'b0;

      // reset state
      nxt();
      nxt();
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_wr", 32'(fifo_wr), 32'd0);
      chk("rst_data", 32'(fifo_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);

      // single requester, three-word packet
      nxt();
      reset = 1'b0;
      req   = 4'b0001;
      set_word(0, 8'h11);
      #1;
      chk_idle("single_req_cycle");
      nxt();
      #1;
      chk_write("single_w1", 4'b0001, 8'h11);
      nxt();
      set_word(0, 8'h22);
      #1;
      chk_write("single_w2", 4'b0001, 8'h22);
      nxt();
      set_word(0, 8'h33);
      req_last = 4'b0001;
      #1;
      chk_write("single_w3", 4'b0001, 8'h33);
      nxt();
      req      = '0;
      req_last = '0;
      #1;
      chk_idle("single_turnaround");

      // fairness from a fresh reset: order 0,1,2,3,0,1
      nxt();
      reset = 1'b1;
      nxt();
      reset    = 1'b0;
      req      = 4'b1111;
      req_last = 4'b1111;
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int k = 0; k < 6; k++) begin
         #1;
         chk_idle($sformatf("fair_idle%0d", k));
         nxt();
         #1;
         chk_write($sformatf("fair_grant%0d", k), 4'(1 << (k % 4)), 8'hA0 + 8'(k % 4));
         nxt();
      end
      req      = '0;
      req_last = '0;
      #1;
      chk_idle("fair_end");

      // burst cap on requester 2, then re-grant while alone, then yield to requester 0
      nxt();
      req = 4'b0100;
      set_word(2, 8'hC0);
      #1;
      chk_idle("burst_req_cycle");
      for (int j = 0; j < 4; j++) begin
         nxt();
         set_word(2, 8'hC0 + 8'(j));
         #1;
         chk_write($sformatf("burst_a%0d", j), 4'b0100, 8'hC0 + 8'(j));
      end
      nxt();
      set_word(2, 8'hC4);
      #1;
      chk_idle("burst_cap_turnaround");
      for (int j = 4; j < 8; j++) begin
         nxt();
         set_word(2, 8'hC0 + 8'(j));
         #1;
         chk_write($sformatf("burst_b%0d", j), 4'b0100, 8'hC0 + 8'(j));
      end
      nxt();
      req = 4'b0101;
      set_word(0, 8'h77);
      #1;
      chk_idle("burst_second_turnaround");
      nxt();
      req = '0;
      #1;
      chk("burst_yield_gnt", 32'(gnt), 32'd1);
      chk("burst_drop_wr", 32'(fifo_wr), 32'd0);
      nxt();
      #1;
      chk_idle("burst_drop_release");

      // backpressure: five full cycles after the first word of requester 1
      nxt();
      req = 4'b0010;
      set_word(1, 8'hD0);
      #1;
      chk_idle("bp_req_cycle");
      nxt();
      #1;
      chk_write("bp_w0", 4'b0010, 8'hD0);
      nxt();
      fifo_full = 1'b1;
      set_word(1, 8'hD1);
      for (int s = 0; s < 5; s++) begin
         #1;
         chk($sformatf("bp_stall%0d_wr", s), 32'(fifo_wr), 32'd0);
         chk($sformatf("bp_stall%0d_ack", s), 32'(ack), 32'd0);
         chk($sformatf("bp_stall%0d_data", s), 32'(fifo_data), 32'd0);
         chk($sformatf("bp_stall%0d_gnt", s), 32'(gnt), 32'b0010);
         nxt();
      end
      fifo_full = 1'b0;
      for (int j = 1; j < 4; j++) begin
         set_word(1, 8'hD0 + 8'(j));
         #1;
         chk_write($sformatf("bp_w%0d", j), 4'b0010, 8'hD0 + 8'(j));
         nxt();
      end
      req = '0;
      #1;
      chk_idle("bp_release");

      // reset in the middle of a burst, then priority restarts at requester 0
      nxt();
      req = 4'b1000;
      set_word(3, 8'hE0);
      #1;
      chk_idle("rstmid_req_cycle");
      nxt();
      #1;
      chk_write("rstmid_w0", 4'b1000, 8'hE0);
      nxt();
      set_word(3, 8'hE1);
      reset = 1'b1;
      #1;
      chk("rstmid_gnt", 32'(gnt), 32'd0);
      chk("rstmid_ack", 32'(ack), 32'd0);
      chk("rstmid_wr", 32'(fifo_wr), 32'd0);
      chk("rstmid_data", 32'(fifo_data), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_timeout", 32'(timeout), 32'd0);
      nxt();
      reset    = 1'b0;
      req      = 4'b1010;
      req_last = 4'b0010;
      set_word(1, 8'h5A);
      #1;
      chk_idle("rstmid_after_idle");
      nxt();
      #1;
      chk_write("rstmid_regrant", 4'b0010, 8'h5A);
      nxt();
      req      = '0;
      req_last = '0;
      #1;
      chk_idle("rstmid_end");

      // FIFO stuck full with requesters 0 and 1 pending
      nxt();
      req       = 4'b0011;
      fifo_full = 1'b1;
      set_word(0, 8'h99);
      #1;
      chk_idle("stuck_req_cycle");
      nxt();
`ifdef ARB_TIMEOUT_EN
      for (int c = 1; c < 16; c++) begin
         #1;
         chk($sformatf("to_stall%0d_gnt", c), 32'(gnt), 32'd1);
         chk($sformatf("to_stall%0d_timeout", c), 32'(timeout), 32'd0);
         chk($sformatf("to_stall%0d_wr", c), 32'(fifo_wr), 32'd0);
         nxt();
      end
      #1;
      chk("to_pulse", 32'(timeout), 32'd1);
      chk("to_pulse_gnt", 32'(gnt), 32'd1);
      nxt();
      #1;
      chk_idle("to_revoked");
      chk("to_pulse_end", 32'(timeout), 32'd0);
      nxt();
      req       = '0;
      fifo_full = 1'b0;
      #1;
      chk("to_next_owner", 32'(gnt), 32'b0010);
      chk("to_next_wr", 32'(fifo_wr), 32'd0);
      nxt();
      #1;
      chk_idle("to_end");
`else
      for (int c = 1; c <= 20; c++) begin
         #1;
         chk($sformatf("hold%0d_gnt", c), 32'(gnt), 32'd1);
         chk($sformatf("hold%0d_busy", c), 32'(busy), 32'd1);
         chk($sformatf("hold%0d_timeout", c), 32'(timeout), 32'd0);
         chk($sformatf("hold%0d_wr", c), 32'(fifo_wr), 32'd0);
         nxt();
      end
      req       = '0;
      fifo_full = 1'b0;
      #1;
      chk("hold_drop_gnt", 32'(gnt), 32'd1);
      chk("hold_drop_wr", 32'(fifo_wr), 32'd0);
      nxt();
      #1;
      chk_idle("hold_end");
`endif

      // scoreboard: FIFO contents in order, nothing lost or duplicated
      nxt();
      #3;
      chk("fifo_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int n = 0; n < exp_q.size(); n++) begin
         if (n < got_q.size()) begin
            chk($sformatf("fifo_word%0d", n), 32'(got_q[n]), 32'(exp_q[n]));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
